// File: rtl/exunit_alu_pipe.sv
// Two-stage integer execute pipe: E1 holds the issued uop with its selected
// operands, E2 holds the ALU result awaiting the writeback arbiter.
module exunit_alu_pipe #(
  parameter int DATA_LEN     = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int RRF_SEL      = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    kill_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] issue_op_i,
  input  logic [DATA_LEN-1:0]     issue_src1_i,
  input  logic [DATA_LEN-1:0]     issue_src2_i,
  input  logic [DATA_LEN-1:0]     issue_imm_i,
  input  logic [DATA_LEN-1:0]     issue_pc_i,
  input  logic [1:0]              issue_sel1_i,
  input  logic [1:0]              issue_sel2_i,
  input  logic [RRF_SEL-1:0]      issue_rrftag_i,
  input  logic                    issue_dstval_i,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [DATA_LEN-1:0]     result_data_o,
  output logic [RRF_SEL-1:0]      result_rrftag_o,
  output logic                    result_dstval_o,
  output logic                    busy_o
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SEQ  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SNE  = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(12);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGE  = ALU_OP_WIDTH'(13);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU = ALU_OP_WIDTH'(14);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SGEU = ALU_OP_WIDTH'(15);

  logic                    e1_valid, e2_valid;
  logic [ALU_OP_WIDTH-1:0] e1_op;
  logic [DATA_LEN-1:0]     e1_in1, e1_in2;
  logic [RRF_SEL-1:0]      e1_tag;
  logic                    e1_dst;

  logic [DATA_LEN-1:0]     sel_in1, sel_in2, alu_res;
  logic                    e2_free, e1_adv, issue_fire;
  logic [4:0]              shamt;

  assign e2_free       = !e2_valid || result_ready_i;
  assign e1_adv        = e1_valid && e2_free;
  assign issue_ready_o = !kill_i && (!e1_valid || e1_adv);
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign busy_o        = e1_valid || e2_valid;
  assign result_valid_o = e2_valid;

  always_comb begin
    sel_in1 = '0;
    case (issue_sel1_i)
      2'd0:    sel_in1 = issue_src1_i;
      2'd1:    sel_in1 = issue_pc_i;
      default: sel_in1 = '0;
    endcase
  end

  always_comb begin
    sel_in2 = '0;
    case (issue_sel2_i)
      2'd0:    sel_in2 = issue_src2_i;
      2'd1:    sel_in2 = issue_imm_i;
      2'd2:    sel_in2 = DATA_LEN'(4);
      default: sel_in2 = '0;
    endcase
  end

  assign shamt = e1_in2[4:0];

  // Compares return 0/1 zero-extended; unused encodings return 0.
  always_comb begin
    alu_res = '0;
    case (e1_op)
      OP_ADD:  alu_res = e1_in1 + e1_in2;
      OP_SUB:  alu_res = e1_in1 - e1_in2;
      OP_SLL:  alu_res = e1_in1 << shamt;
      OP_SRL:  alu_res = e1_in1 >> shamt;
      OP_SRA:  alu_res = DATA_LEN'($signed(e1_in1) >>> shamt);
      OP_XOR:  alu_res = e1_in1 ^ e1_in2;
      OP_OR:   alu_res = e1_in1 | e1_in2;
      OP_AND:  alu_res = e1_in1 & e1_in2;
      OP_SEQ:  alu_res = DATA_LEN'(e1_in1 == e1_in2);
      OP_SNE:  alu_res = DATA_LEN'(e1_in1 != e1_in2);
      OP_SLT:  alu_res = DATA_LEN'($signed(e1_in1) < $signed(e1_in2));
      OP_SGE:  alu_res = DATA_LEN'($signed(e1_in1) >= $signed(e1_in2));
      OP_SLTU: alu_res = DATA_LEN'(e1_in1 < e1_in2);
      OP_SGEU: alu_res = DATA_LEN'(e1_in1 >= e1_in2);
      default: alu_res = '0;
    endcase
  end

  // Control and result registers; kill wins over issue, advance and drain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e1_valid        <= 1'b0;
      e2_valid        <= 1'b0;
      result_data_o   <= '0;
      result_rrftag_o <= '0;
      result_dstval_o <= 1'b0;
    end else if (kill_i) begin
      e1_valid <= 1'b0;
      e2_valid <= 1'b0;
    end else begin
      if (e1_adv) begin
        e2_valid        <= 1'b1;
        result_data_o   <= alu_res;
        result_rrftag_o <= e1_tag;
        result_dstval_o <= e1_dst;
      end else if (e2_valid && result_ready_i) begin
        e2_valid <= 1'b0;
      end
      if (issue_fire)  e1_valid <= 1'b1;
      else if (e1_adv) e1_valid <= 1'b0;
    end
  end

  // E1 payload only matters while e1_valid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      e1_op  <= issue_op_i;
      e1_in1 <= sel_in1;
      e1_in2 <= sel_in2;
      e1_tag <= issue_rrftag_i;
      e1_dst <= issue_dstval_i;
    end
  end

endmodule

// File: tb/tb_exunit_alu_pipe.sv
// Self-checking bench for exunit_alu_pipe: directed scenarios plus a
// randomized run scored against an in-order queue model.
module tb_exunit_alu_pipe;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, kill_i = 1'b0;
  logic        issue_valid_i = 1'b0, issue_ready_o;
  logic [3:0]  issue_op_i = '0;
  logic [31:0] issue_src1_i = '0, issue_src2_i = '0, issue_imm_i = '0, issue_pc_i = '0;
  logic [1:0]  issue_sel1_i = '0, issue_sel2_i = '0;
  logic [5:0]  issue_rrftag_i = '0;
  logic        issue_dstval_i = 1'b0;
  logic        result_valid_o, result_ready_i = 1'b1;
  logic [31:0] result_data_o;
  logic [5:0]  result_rrftag_o;
  logic        result_dstval_o, busy_o;

  int tests = 0;
  int fails = 0;

  exunit_alu_pipe #(.DATA_LEN(32), .ALU_OP_WIDTH(4), .RRF_SEL(6)) dut (
    .clk_i(clk), .reset_i(reset_i), .kill_i(kill_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_src1_i(issue_src1_i), .issue_src2_i(issue_src2_i),
    .issue_imm_i(issue_imm_i), .issue_pc_i(issue_pc_i),
    .issue_sel1_i(issue_sel1_i), .issue_sel2_i(issue_sel2_i),
    .issue_rrftag_i(issue_rrftag_i), .issue_dstval_i(issue_dstval_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_rrftag_o(result_rrftag_o),
    .result_dstval_o(result_dstval_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference ALU written from the opcode semantics, not from the RTL.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sum;
    int     sh;
    sh = int'(b % 32);
    case (op)
      0:  begin sum = longint'(a) + longint'(b); return sum[31:0]; end
      10: begin sum = longint'(a) + 64'h1_0000_0000 - longint'(b); return sum[31:0]; end
      1:  return a * (32'd1 << sh);
      5:  return a / (32'd1 << sh);
      11: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4:  return a ^ b;
      6:  return a | b;
      7:  return a & b;
      8:  return (a == b) ? 32'd1 : 32'd0;
      9:  return (a == b) ? 32'd0 : 32'd1;
      12: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      13: return (int'(a) < int'(b)) ? 32'd0 : 32'd1;
      14: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      15: return (longint'(a) < longint'(b)) ? 32'd0 : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_in1(input logic [1:0] s, input logic [31:0] src1, input logic [31:0] pc);
    return (s == 2'd0) ? src1 : (s == 2'd1) ? pc : 32'd0;
  endfunction

  function automatic logic [31:0] ref_in2(input logic [1:0] s, input logic [31:0] src2, input logic [31:0] imm);
    return (s == 2'd0) ? src2 : (s == 2'd1) ? imm : (s == 2'd2) ? 32'd4 : 32'd0;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] sel1,
                       input logic [1:0] sel2, input logic [5:0] tag, input logic dst);
    issue_valid_i = 1'b1; issue_op_i = op; issue_src1_i = s1; issue_src2_i = s2;
    issue_imm_i = imm; issue_pc_i = pc; issue_sel1_i = sel1; issue_sel2_i = sel2;
    issue_rrftag_i = tag; issue_dstval_i = dst;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; issue_valid_i = 1'b0; result_ready_i = 1'b1;
    next_cycle(); next_cycle();
    reset_i = 1'b0;
    @(negedge clk);
    tests++; if (result_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", result_valid_o); end
    tests++; if ({result_data_o, result_rrftag_o, result_dstval_o} !== 39'd0) begin fails++; $display("FAIL reset_result got=%h/%h/%b want=0", result_data_o, result_rrftag_o, result_dstval_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    tests++; if (issue_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", issue_ready_o); end
    next_cycle();
  endtask

  task automatic test_single();
    result_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(4'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 2'd0, 2'd1, 6'd7, 1'b1);
      else issue_valid_i = 1'b0;
      @(negedge clk);
      if (c == 0) begin
        tests++; if (issue_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready got=%b want=1", issue_ready_o); end
      end
      tests++; if (result_valid_o !== (c == 2)) begin fails++; $display("FAIL single_valid c=%0d got=%b want=%b", c, result_valid_o, c == 2); end
      if (c == 2) begin
        tests++; if (result_data_o !== 32'd2 || result_rrftag_o !== 6'd7 || result_dstval_o !== 1'b1)
          begin fails++; $display("FAIL single_data got=%h/%0d/%b want=2/7/1", result_data_o, result_rrftag_o, result_dstval_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = ref_alu(10, 32'd3, 32'd5);
    exp[1] = ref_alu(1, 32'd1, 32'd33);
    exp[2] = ref_alu(12, 32'hFFFF_FFFF, 32'd0);
    exp[3] = ref_alu(14, 32'hFFFF_FFFF, 32'd0);
    result_ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(4'd10, 32'd3, 32'd5, 32'd0, 32'd0, 2'd0, 2'd0, 6'd10, 1'b1);
        1: drive(4'd1, 32'd1, 32'd33, 32'd0, 32'd0, 2'd0, 2'd0, 6'd11, 1'b1);
        2: drive(4'd12, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 6'd12, 1'b1);
        3: drive(4'd14, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 6'd13, 1'b1);
        default: issue_valid_i = 1'b0;
      endcase
      @(negedge clk);
      if (c < 4) begin
        tests++; if (issue_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready c=%0d got=%b want=1", c, issue_ready_o); end
      end
      tests++; if (result_valid_o !== (c >= 2 && c < 6)) begin fails++; $display("FAIL b2b_valid c=%0d got=%b", c, result_valid_o); end
      if (c >= 2 && c < 6) begin
        tests++; if (result_data_o !== exp[c-2] || result_rrftag_o !== 6'(10 + c - 2))
          begin fails++; $display("FAIL b2b_data c=%0d got=%h/%0d want=%h/%0d", c, result_data_o, result_rrftag_o, exp[c-2], 10 + c - 2); end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [3];
    exp[0] = 32'd11; exp[1] = 32'd22; exp[2] = 32'd33;
    result_ready_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c <= 5) drive(4'd0, 32'd11 * (c > 2 ? 3 : c + 1), 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 6'(20 + (c > 2 ? 2 : c)), 1'b1);
      else issue_valid_i = 1'b0;
      if (c >= 5) result_ready_i = 1'b1;
      @(negedge clk);
      if (c <= 5) begin
        tests++; if (issue_ready_o !== (c < 2 || c == 5)) begin fails++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, issue_ready_o, c < 2 || c == 5); end
      end
      tests++; if (result_valid_o !== (c >= 2 && c <= 7)) begin fails++; $display("FAIL bp_valid c=%0d got=%b", c, result_valid_o); end
      if (c >= 2 && c <= 7) begin
        tests++; if (result_data_o !== exp[c <= 5 ? 0 : c - 5] || result_rrftag_o !== 6'(20 + (c <= 5 ? 0 : c - 5)))
          begin fails++; $display("FAIL bp_data c=%0d got=%h/%0d want=%h", c, result_data_o, result_rrftag_o, exp[c <= 5 ? 0 : c - 5]); end
      end
      if (c == 8) begin
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL bp_busy got=%b want=0", busy_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_pc_rel();
    result_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(4'd0, 32'hDEAD_BEEF, 32'h1234, 32'h55, 32'h1000, 2'd1, 2'd2, 6'd33, 1'b1);
      else if (c == 1) drive(4'd0, 32'd9, 32'd0, 32'd0, 32'h2000, 2'd2, 2'd3, 6'd34, 1'b0);
      else issue_valid_i = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        tests++; if (result_valid_o !== 1'b1 || result_data_o !== 32'h1004 || result_dstval_o !== 1'b1 || result_rrftag_o !== 6'd33)
          begin fails++; $display("FAIL pcrel got=%b/%h/%b/%0d want=1/1004/1/33", result_valid_o, result_data_o, result_dstval_o, result_rrftag_o); end
      end
      if (c == 3) begin
        tests++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd0 || result_dstval_o !== 1'b0)
          begin fails++; $display("FAIL zero_sel got=%b/%h/%b want=1/0/0", result_valid_o, result_data_o, result_dstval_o); end
      end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic test_kill();
    result_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      kill_i = (c == 3);
      if (c < 2 || c == 3) drive(4'd0, 32'd100 + c, 32'd1, 32'd0, 32'd0, 2'd0, 2'd0, 6'(40 + c), 1'b1);
      else issue_valid_i = 1'b0;
      if (c >= 4) result_ready_i = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        tests++; if (issue_ready_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL kill_full got=%b/%b want=0/1", issue_ready_o, busy_o); end
      end
      if (c == 3) begin
        tests++; if (issue_ready_o !== 1'b0) begin fails++; $display("FAIL kill_ready got=%b want=0", issue_ready_o); end
      end
      if (c >= 4) begin
        tests++; if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL kill_clear c=%0d got=%b/%b want=0/0", c, result_valid_o, busy_o); end
      end
      next_cycle();
    end
    kill_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    result_ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      reset_i = (c == 3);
      if (c < 2) drive(4'd4, 32'hF0F0_0000 + c, 32'h0F0F, 32'd0, 32'd0, 2'd0, 2'd0, 6'(50 + c), 1'b1);
      else if (c == 4) drive(4'd6, 32'hA000_0000, 32'h5, 32'd0, 32'd0, 2'd0, 2'd0, 6'd63, 1'b1);
      else issue_valid_i = 1'b0;
      if (c >= 4) result_ready_i = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        tests++; if (result_valid_o !== 1'b1 || busy_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre got=%b/%b want=1/1", result_valid_o, busy_o); end
      end
      if (c == 4) begin
        tests++; if ({result_valid_o, result_data_o, result_rrftag_o, result_dstval_o, busy_o} !== 41'd0)
          begin fails++; $display("FAIL rstmid_outs got=%b/%h/%h/%b/%b want=0", result_valid_o, result_data_o, result_rrftag_o, result_dstval_o, busy_o); end
        tests++; if (issue_ready_o !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b want=1", issue_ready_o); end
      end
      if (c >= 5) begin
        tests++; if (result_valid_o !== (c == 6) || (c == 6 && (result_data_o !== 32'hA000_0005 || result_rrftag_o !== 6'd63)))
          begin fails++; $display("FAIL rstmid_after c=%0d got=%b/%h/%0d", c, result_valid_o, result_data_o, result_rrftag_o); end
      end
      next_cycle();
    end
    reset_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_random();
    logic [38:0] q [$];
    logic [38:0] head, prev;
    logic        pv, prr, pk, exp_rdy;
    pv = 1'b0; prr = 1'b0; pk = 1'b0; prev = '0;
    for (int c = 0; c < 1200; c++) begin
      kill_i = (c < 1190) && ($urandom_range(0, 39) == 0);
      result_ready_i = (c >= 1190) || ($urandom_range(0, 2) != 0);
      if (c < 1190 && $urandom_range(0, 3) != 0)
        drive(4'($urandom_range(0, 15)), ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)), $urandom, $urandom,
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom));
      else issue_valid_i = 1'b0;
      @(negedge clk);
      exp_rdy = !kill_i && (q.size() < 2 || result_ready_i);
      tests++; if (issue_ready_o !== exp_rdy) begin fails++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, issue_ready_o, exp_rdy); end
      tests++; if (busy_o !== (q.size() != 0)) begin fails++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy_o, q.size() != 0); end
      if (pv && !prr && !pk) begin
        tests++; if (result_valid_o !== 1'b1 || {result_dstval_o, result_rrftag_o, result_data_o} !== prev)
          begin fails++; $display("FAIL rnd_hold c=%0d got=%b/%h want=1/%h", c, result_valid_o, {result_dstval_o, result_rrftag_o, result_data_o}, prev); end
      end
      if (result_valid_o === 1'b1 && result_ready_i) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL rnd_spurious c=%0d got=%h want=none", c, result_data_o); end
        else begin
          head = q.pop_front();
          if ({result_dstval_o, result_rrftag_o, result_data_o} !== head)
            begin fails++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, {result_dstval_o, result_rrftag_o, result_data_o}, head); end
        end
      end
      if (kill_i) q.delete();
      else if (issue_valid_i && issue_ready_o === 1'b1)
        q.push_back({issue_dstval_i, issue_rrftag_i,
                     ref_alu(int'(issue_op_i), ref_in1(issue_sel1_i, issue_src1_i, issue_pc_i),
                             ref_in2(issue_sel2_i, issue_src2_i, issue_imm_i))});
      pv = result_valid_o; prr = result_ready_i; pk = kill_i;
      prev = {result_dstval_o, result_rrftag_o, result_data_o};
      next_cycle();
    end
    kill_i = 1'b0;
    tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_drain left=%0d want=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_pc_rel();
    test_kill();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exunit_alu_pipe.md
Name: exunit_alu_pipe

Overview:
- Two-stage integer execute pipe between the ALU reservation station (upstream) and the CDB/writeback arbiter (downstream).
- Stage E1 registers the issued µop and its selected operands. The existing combinational ALU then computes the result from E1, and stage E2 registers that result for broadcast.
- Valid/ready handshakes on both sides, full backpressure, and a synchronous kill for misprediction flush.

Parameters:
- DATA_LEN, 32: operand/result width.
- ALU_OP_WIDTH, 4: ALU opcode width, using the encodings from the ALU constants header.
- RRF_SEL, 6: rename-register (destination tag) width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- kill_i  in  1  flush: drops all in-flight µops.
- issue_valid_i  in  1  RS presents a µop.
- issue_ready_o  out  1  pipe accepts the µop this cycle.
- issue_op_i  in  ALU_OP_WIDTH  ALU opcode.
- issue_src1_i  in  DATA_LEN  register operand 1.
- issue_src2_i  in  DATA_LEN  register operand 2.
- issue_imm_i  in  DATA_LEN  sign-extended immediate.
- issue_pc_i  in  DATA_LEN  µop PC.
- issue_sel1_i  in  2  in1 select: 0=src1, 1=pc, 2=zero, 3=zero.
- issue_sel2_i  in  2  in2 select: 0=src2, 1=imm, 2=constant 4, 3=zero.
- issue_rrftag_i  in  RRF_SEL  destination tag.
- issue_dstval_i  in  1  µop writes a register.
- result_valid_o  out  1  E2 holds a result.
- result_ready_i  in  1  arbiter takes the result this cycle.
- result_data_o  out  DATA_LEN  ALU result.
- result_rrftag_o  out  RRF_SEL  tag of the result.
- result_dstval_o  out  1  dstval of the result.
- busy_o  out  1  any stage valid.

Behaviour:
- Clocking/reset: single clock clk_i; reset_i is synchronous, active-high.
- Reset: E1/E2 valid=0.
  - result_valid_o=0, result_data_o=0, result_rrftag_o=0, result_dstval_o=0, busy_o=0.
  - issue_ready_o=1 in the first cycle after reset, since both stages are empty.
- Handshakes:
  - Transfer occurs on a cycle where valid && ready, on each side.
  - result_data_o/tag/dstval are held stable while result_valid_o=1 and result_ready_i=0.
- Operand select is done at issue. E1 stores in1/in2/op/tag/dstval, not the raw sources.
- ALU semantics:
  - ALU op semantics are exactly the existing ALU's.
  - Shifts use in2[4:0]; compares produce 0/1 zero-extended.
  - Add/sub wrap modulo 2^DATA_LEN.
  - Unknown op yields 0.
- Advance rules, evaluated each cycle:
  - e2_free = !e2_valid || result_ready_i.
  - e1_adv = e1_valid && e2_free: E2 loads the ALU(E1) result, tag and dstval; e2_valid=1.
  - If e2_valid && result_ready_i && !e1_adv, then e2_valid=0.
  - issue_ready_o = !kill_i && (!e1_valid || e1_adv). This is combinational and does not depend on issue_valid_i.
  - Issue fire loads E1; otherwise, if e1_adv, e1_valid=0.
- Latency and throughput:
  - Accepted µop: result_valid_o rises exactly 2 cycles after the issue fire edge, when there is no backpressure.
  - Throughput is 1 µop/cycle sustained.
- Backpressure and buffering:
  - Capacity is 2 µops. When result_ready_i is held low, the pipe fills after 2 accepts, then issue_ready_o=0.
  - When result_ready_i returns to 1, E2 drains and E1 advances in the same cycle, and issue_ready_o=1 in that same cycle.
- Kill:
  - kill_i=1 clears e1_valid and e2_valid at the next edge. It takes priority over issue, advance and drain.
  - issue_ready_o=0 while kill_i=1, so no µop is accepted.
  - result_valid_o may be high in the kill cycle. A handshake in that cycle still counts as delivered; the bench must allow either.
- Reset mid-operation: same as kill, and all outputs return to their reset values.
- Data registers: datapath registers need not be cleared when their valid bit is 0, except result_* outputs, which are reset to 0.
- busy_o = e1_valid || e2_valid, registered-state based.

Test Plan:
- Single op: issue ADD, sel1=0, sel2=1, src1=5, imm=0xFFFFFFFD, tag=7; result_ready_i=1 -> 2 cycles later result_valid_o=1, result_data_o=2, result_rrftag_o=7, for exactly one cycle.
- Back-to-back: 4 µops on consecutive cycles (SUB 3-5, SLL 1<<33 via src2=33, SLT -1<0, SLTU 0xFFFFFFFF<0) -> results 0xFFFFFFFE, 2, 1, 0 on 4 consecutive cycles, in order.
- Backpressure: result_ready_i=0, issue 3 µops -> 2 accepted; issue_ready_o=0 on the third attempt; result held stable. Raise ready -> the 3 results arrive in order, no loss or duplication.
- PC-relative: sel1=1, sel2=2, pc=0x1000, op ADD -> result_data_o=0x1004, dstval propagated.
- Kill: pipe full and stalled, pulse kill_i together with issue_valid_i -> next cycle result_valid_o=0, busy_o=0, issue_ready_o=0 during the kill cycle, and no result ever appears for the killed or issued µops.
- Reset mid-stream: assert reset_i with E1 and E2 valid -> all outputs are 0 next cycle; the next issue after deassert completes in 2 cycles.
